latch_strobe_tx: RTL and testbench
==================================

// Module: latch_strobe_tx
// PURPOSE
//  Source end of the level-sensitive latch interface: drives data and a latch-enable strobe to a downstream transparent latch.
//  Data is accepted from a ready/valid source and presented with guaranteed setup before, and hold after, the strobe.
//  Sequence per word: SETUP (le low, data stable), STROBE (le high), HOLD (le low, data stable).
//  Sits between a streaming producer and latch-based storage or parallel output registers.
// PARAMETERS
//  WIDTH       8  data width in bits
//  SETUP_CYC   2  cycles dout is stable with le low before le rises (>=1)
//  STROBE_CYC  2  cycles le is held high (>=1)
//  HOLD_CYC    1  cycles dout is stable with le low after le falls (>=1)
// PORTS
//  clk       in   1      single clock, all state on rising edge
//  rst       in   1      synchronous, active-high reset
//  in_valid  in   1      producer has a word on in_data
//  in_ready  out  1      block can accept a word this cycle
//  in_data   in   WIDTH  word to transmit
//  dout      out  WIDTH  data to latch D input (registered)
//  le        out  1      latch enable to latch clk/gate input (registered)
//  busy      out  1      transaction in progress (state != IDLE)
//  done      out  1      one-cycle pulse during final HOLD cycle
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, dout=0, le=0, done=0, counter=0; in_ready=0 while rst is high.
//  in_ready = (state==IDLE) & ~rst (combinational); busy = (state!=IDLE).
//  Accept: in_valid & in_ready at edge N -> dout<=in_data, state<=SETUP, cnt<=0.
//  SETUP: le=0 for SETUP_CYC cycles; at the last one, le<=1, state<=STROBE.
//  STROBE: le=1 for STROBE_CYC cycles; at the last one, le<=0, state<=HOLD.
//  HOLD: le=0 for HOLD_CYC cycles; done=1 in the final HOLD cycle; then state<=IDLE.
//  le is high for cycles N+SETUP_CYC+1 through N+SETUP_CYC+STROBE_CYC, counted from the accept edge.
//  Word period = SETUP_CYC+STROBE_CYC+HOLD_CYC (+1 IDLE cycle without the optional feature).
//  dout changes only on an accept edge and never while le=1 or during HOLD; it retains its value in IDLE.
//  in_data and in_valid are ignored while busy; the producer holds in_data until accepted.
//  Counter width: $clog2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC))+1; it wraps to 0 on each state change.
//  le is never high in IDLE, SETUP or HOLD; le is glitch-free because it is driven straight from a flop.
//  Reset mid-transaction: at the next edge le=0, dout=0, state=IDLE, and the in-flight word is dropped.
//  in_valid asserted during reset is not accepted until the first cycle with rst=0.
// CONFIGURATION
//  LATCH_STROBE_B2B_EN defined:
//   in_ready is also 1 in the final HOLD cycle.
//   An accept there loads dout and enters SETUP at the next edge with no IDLE cycle.
//   Word period becomes exactly SETUP_CYC+STROBE_CYC+HOLD_CYC.
//   Hold is still honoured: dout changes only at the edge that ends HOLD.
//  Not defined: in_ready is 1 only in IDLE, giving at least 1 IDLE cycle between words.
// TESTING  (WIDTH=8, SETUP_CYC=2, STROBE_CYC=2, HOLD_CYC=1; behavioural latch model on dout/le)
//  Reset: rst=1 for 2 cycles with in_valid=1 -> le=0, dout=0, in_ready=0, busy=0; no accept until rst=0.
//  Single word 0xA5 accepted at edge N -> dout=0xA5 from N.
//   le=1 in cycles N+3..N+4; done in N+5; IDLE at N+6; latch q=0xA5.
//  Back-to-back 0x3C then 0xC3, in_valid held high:
//   macro off -> second accept 6 cycles after the first.
//   macro on -> second accept 5 cycles after the first.
//   Latch q sequence is 0x3C then 0xC3, and dout never changes while le=1.
//  in_data toggled every cycle while busy -> dout and latch q stay at the accepted word.
//  rst pulsed during STROBE -> le=0 and dout=0 the next cycle; latch holds the old value.
//   A following word 0x5A transmits normally.
//  Params SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=1 -> le high for exactly one cycle at N+2; done at N+3.

Source files
------------

// File: rtl/latch_strobe_tx.sv
// Latch-interface source: presents each accepted word with setup, strobe and hold phases on le.
// Define LATCH_STROBE_B2B_EN to accept the next word in the final HOLD cycle (no IDLE gap).
module latch_strobe_tx #(
   parameter int WIDTH      = 8,
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] dout,
   output logic             le,
   output logic             busy,
   output logic             done
);

   localparam int MAX_SS = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int MAX_C  = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
   localparam int CW     = $clog2(MAX_C) + 1;

   localparam logic [CW-1:0] S_LAST = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] T_LAST = CW'(STROBE_CYC - 1);
   localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYC - 1);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] dout_n;
   logic             le_n, done_n;
   logic             hold_last, accept;

   assign hold_last = (state == HOLD) && (cnt == H_LAST);

`ifdef LATCH_STROBE_B2B_EN
   assign in_ready = ((state == IDLE) || hold_last) && !rst;
`else
   assign in_ready = (state == IDLE) && !rst;
`endif

   assign accept = in_valid && in_ready;
   assign busy   = (state != IDLE);

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      dout_n  = dout;
      le_n    = le;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (accept) begin
               dout_n  = in_data;
               state_n = SETUP;
            end
         end
         SETUP: begin
            if (cnt == S_LAST) begin
               state_n = STROBE;
               cnt_n   = '0;
               le_n    = 1'b1;
            end
         end
         STROBE: begin
            if (cnt == T_LAST) begin
               state_n = HOLD;
               cnt_n   = '0;
               le_n    = 1'b0;
            end
         end
         HOLD: begin
            if (cnt == H_LAST) begin
               cnt_n = '0;
               if (accept) begin
                  dout_n  = in_data;
                  state_n = SETUP;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            le_n    = 1'b0;
         end
      endcase
      // done is registered, so it is raised on the edge that enters the final HOLD cycle
      done_n = (state_n == HOLD) && (cnt_n == H_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         dout  <= '0;
         le    <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         dout  <= dout_n;
         le    <= le_n;
         done  <= done_n;
      end
   end

endmodule

// File: tb/tb_latch_strobe_tx.sv
// Scoreboard bench for latch_strobe_tx: expected latched words queued at issue, checked on each le fall.
module tb_latch_strobe_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_ready, le, busy, done;
   logic [7:0] dout;

   logic       in_valid1 = 1'b0;
   logic [7:0] in_data1 = '0;
   logic       in_ready1, le1, busy1, done1;
   logic [7:0] dout1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] q = '0;
   logic [7:0] exp_q[$];
   logic       le_d = 1'b0;
   logic [7:0] dout_d = '0;
   logic       rst_e = 1'b0;

   always #5 clk = ~clk;

   latch_strobe_tx #(.WIDTH(8), .SETUP_CYC(2), .STROBE_CYC(2), .HOLD_CYC(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .dout(dout), .le(le), .busy(busy), .done(done));

   latch_strobe_tx #(.WIDTH(8), .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
      .dout(dout1), .le(le1), .busy(busy1), .done(done1));

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_e <= rst;
   end

   // behavioural transparent latch, sampled mid-cycle while le is high
   always @(negedge clk) if (le) q <= dout;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: pop on each le falling edge, and watch dout stability under le
   always @(negedge clk) begin
      if (le_d && !le && !rst_e) begin
         if (exp_q.size() == 0) chk("unexpected_strobe", int'(q), -1);
         else chk("latch_q", int'(q), int'(exp_q.pop_front()));
      end
      if (le && le_d) chk("dout_stable_le", int'(dout), int'(dout_d));
      le_d   <= le;
      dout_d <= dout;
   end

   task automatic send(input logic [7:0] w, output int e);
      in_data  = w;
      in_valid = 1'b1;
      e = -1;
      for (int i = 0; i < 40 && e < 0; i++) begin
         if (in_ready) begin
            @(posedge clk); #1;
            e = cyc;
         end else begin
            @(negedge clk);
         end
      end
      if (e < 0) chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int ok = 0;
      for (int i = 0; i < 40 && ok == 0; i++) begin
         @(posedge clk); #1;
         if (!busy) ok = 1;
      end
      if (ok == 0) chk("idle_timeout", 0, 1);
   endtask

   initial begin
      int e1, e2, errs, got;
      logic [5:0] le_v, done_v, busy_v;
      logic [3:0] le_w, done_w;

      // reset held 2 cycles with in_valid high
      in_valid = 1'b1;
      in_data  = 8'h77;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("rst_le", int'(le), 0);
         chk("rst_dout", int'(dout), 0);
         chk("rst_in_ready", int'(in_ready), 0);
         chk("rst_busy", int'(busy), 0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1 chk("ready_after_rst", int'(in_ready), 1);
      exp_q.push_back(8'h77);
      @(posedge clk); #1;
      chk("first_accept_dout", int'(dout), 8'h77);
      in_valid = 1'b0;
      wait_idle();

      // single word timing
      @(negedge clk);
      send(8'hA5, e1);
      exp_q.push_back(8'hA5);
      in_valid = 1'b0;
      chk("single_dout", int'(dout), 8'hA5);
      for (int k = 0; k < 6; k++) begin
         le_v[k]   = le;
         done_v[k] = done;
         busy_v[k] = busy;
         @(posedge clk); #1;
      end
      chk("single_le_pattern", int'(le_v), 6'b001100);
      chk("single_done_pattern", int'(done_v), 6'b010000);
      chk("single_busy_pattern", int'(busy_v), 6'b011111);

      // back-to-back with in_valid held high
      @(negedge clk);
      send(8'h3C, e1);
      exp_q.push_back(8'h3C);
      send(8'hC3, e2);
      exp_q.push_back(8'hC3);
      in_valid = 1'b0;
`ifdef LATCH_STROBE_B2B_EN
      chk("b2b_spacing", e2 - e1, 5);
`else
      chk("b2b_spacing", e2 - e1, 6);
`endif
      wait_idle();

      // input noise while busy is ignored
      @(negedge clk);
      send(8'h96, e1);
      exp_q.push_back(8'h96);
      errs = 0;
      for (int i = 0; i < 20 && busy; i++) begin
         @(negedge clk);
         if (dout !== 8'h96) errs++;
         in_data  = 8'(i * 37 + 1);
         in_valid = !in_ready;
      end
      in_valid = 1'b0;
      chk("busy_ignore_errs", errs, 0);
      wait_idle();

      // reset pulse during STROBE drops the word
      @(negedge clk);
      send(8'h11, e1);
      in_valid = 1'b0;
      got = 0;
      for (int i = 0; i < 20 && got == 0; i++) begin
         if (le) got = 1;
         else begin @(posedge clk); #1; end
      end
      chk("abort_saw_le", got, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_le", int'(le), 0);
      chk("abort_dout", int'(dout), 0);
      chk("abort_busy", int'(busy), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_latch_hold", int'(q), 8'h11);
      send(8'h5A, e1);
      exp_q.push_back(8'h5A);
      in_valid = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);
      chk("final_latch_q", int'(q), 8'h5A);
      chk("scoreboard_empty", exp_q.size(), 0);

      // minimum-cycle configuration
      @(negedge clk);
      in_data1  = 8'h3E;
      in_valid1 = 1'b1;
      got = 0;
      for (int i = 0; i < 10 && got == 0; i++) begin
         if (in_ready1) got = 1;
         else @(negedge clk);
      end
      chk("min_ready", got, 1);
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      chk("min_dout", int'(dout1), 8'h3E);
      for (int k = 0; k < 4; k++) begin
         le_w[k]   = le1;
         done_w[k] = done1;
         @(posedge clk); #1;
      end
      chk("min_le_pattern", int'(le_w), 4'b0010);
      chk("min_done_pattern", int'(done_w), 4'b0100);
      chk("min_idle", int'(busy1), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
